// File: rtl/sram_fifo_v2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_fifo_v2_pkg
// Description : Shared types and helpers for the SRAM-backed FIFO: the SRAM
//               arbiter op encoding and a pointer increment that wraps at an
//               arbitrary (non power-of-two) depth.
// Revision    : 2.0 - initial release of the v2 FIFO slice
// ============================================================================
package sram_fifo_v2_pkg;

    typedef enum logic [1:0] {
        OP_IDLE = 2'd0,
        OP_WR   = 2'd1,
        OP_RD   = 2'd2
    } sram_op_e;

    // Returns {wrap_toggle, next_index}. The index wraps from depth-1 back to
    // 0, and bit 32 tells the caller to flip its wrap bit.
    function automatic logic [32:0] ptr_inc(input logic [31:0] idx, input int unsigned depth);
        if (idx == depth - 1) begin
            return {1'b1, 32'd0};
        end
        return {1'b0, idx + 32'd1};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_fifo_v2_obuf.sv
`default_nettype none
// ============================================================================
// Module      : sram_fifo_v2_obuf
// Description : Two-entry in-order output buffer. Captures words from the
//               SRAM read port (or the bypass path) and presents the head.
//               Capture and pop may happen in the same cycle.
// Revision    : 2.0 - initial release
// ============================================================================
module sram_fifo_v2_obuf #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cap_i,
    input  logic [DATA_W-1:0] cap_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic [1:0]        cnt_o
);

    logic [DATA_W-1:0] ent0_q, ent0_d;
    logic [DATA_W-1:0] ent1_q, ent1_d;
    logic [1:0]        cnt_q, cnt_d;

    // Next-state: entry 0 is always the head; a pop shifts entry 1 down.
    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        cnt_d  = cnt_q;
        case ({cap_i, pop_i})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    ent0_d = cap_data_i;
                end else begin
                    ent1_d = cap_data_i;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                ent0_d = ent1_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    ent0_d = cap_data_i;
                end else begin
                    ent0_d = ent1_q;
                    ent1_d = cap_data_i;
                end
            end
            default: begin
            end
        endcase
    end

    // State register for the buffer entries and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0_q <= '0;
            ent1_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            cnt_q  <= cnt_d;
        end
    end

    assign data_o  = ent0_q;
    assign valid_o = (cnt_q != 2'd0);
    assign cnt_o   = cnt_q;

endmodule
`default_nettype wire

// File: rtl/sram_wrapper.sv
`default_nettype none
// ============================================================================
// Module      : sram_wrapper
// Description : Single-port synchronous SRAM, one op per cycle. Reads have a
//               latency of one cycle; rd_data_val flags the cycle in which
//               rdata holds the requested row.
// Revision    : 1.1 - rd_data_val cleared by reset
// ============================================================================
module sram_wrapper #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 100,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rd_data_val
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic              rd_val_q;

    // Storage array and read register; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_q[addr] <= wdata;
            end else begin
                rdata_q <= mem_q[addr];
            end
        end
    end

    // Read-valid flag, dropped by reset so an in-flight read is discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_val_q <= 1'b0;
        end else begin
            rd_val_q <= en & ~we;
        end
    end

    assign rdata       = rdata_q;
    assign rd_data_val = rd_val_q;

endmodule
`default_nettype wire

// File: rtl/sram_fifo_v2.sv
`default_nettype none
// ============================================================================
// Module      : sram_fifo_v2
// Description : SRAM-backed FIFO. Input stage (1) -> single-port SRAM (DEPTH)
//               -> output buffer (2); capacity DEPTH+3. One SRAM op per
//               cycle, prefetch reads take priority over writes.
//               Optional macro SRAM_FIFO_V2_BYPASS_EN lets a push go straight
//               into the output buffer when everything ahead of it is empty.
// Revision    : 2.0 - initial release
// ============================================================================
module sram_fifo_v2 #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 100,
    parameter int AF_THRESH = DEPTH,
    parameter int AE_THRESH = 1,
    parameter int CNT_W     = $clog2(DEPTH + 4)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty
);
    import sram_fifo_v2_pkg::*;

    localparam int               IDX_W     = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT    = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_CNT    = CNT_W'(AE_THRESH);

    logic              is_val_q, is_val_d;
    logic [DATA_W-1:0] is_data_q, is_data_d;
    logic [IDX_W-1:0]  widx_q, widx_d, ridx_q, ridx_d;
    logic              wwrap_q, wwrap_d, rwrap_q, rwrap_d;

    logic [CNT_W-1:0]  sram_cnt;
    logic [1:0]        ob_cnt, ob_after_pop;
    logic              push, pop, bypass, rd_data_val, ob_cap;
    logic [DATA_W-1:0] sram_rdata, ob_cap_data;
    logic [32:0]       winc, rinc;
    logic              unused_inc_bits;
    sram_op_e          op;

    assign push         = in_valid & ~is_val_q;
    assign pop          = out_valid & out_ready;
    assign ob_after_pop = ob_cnt - {1'b0, pop};

    // Entries in SRAM, from the index difference corrected by the wrap bits.
    assign sram_cnt = (wwrap_q == rwrap_q)
                    ? CNT_W'(widx_q) - CNT_W'(ridx_q)
                    : DEPTH_CNT - CNT_W'(ridx_q) + CNT_W'(widx_q);

`ifdef SRAM_FIFO_V2_BYPASS_EN
    // Skip IS and SRAM only when nothing older could still be on its way.
    assign bypass = push & (sram_cnt == '0) & ~rd_data_val & (ob_after_pop < 2'd2);
`else
    assign bypass = 1'b0;
`endif

    // Arbiter: prefetch into the output buffer first, otherwise drain IS.
    always_comb begin
        op = OP_IDLE;
        if (mem_en && (sram_cnt != '0) &&
            (({1'b0, ob_after_pop} + {2'b00, rd_data_val}) < 3'd2)) begin
            op = OP_RD;
        end else if (mem_en && is_val_q && (sram_cnt < DEPTH_CNT)) begin
            op = OP_WR;
        end
    end

    assign winc            = ptr_inc(32'(widx_q), DEPTH);
    assign rinc            = ptr_inc(32'(ridx_q), DEPTH);
    assign unused_inc_bits = ^{winc[31:IDX_W], rinc[31:IDX_W]};

    // Next-state for the input stage and the SRAM pointers.
    always_comb begin
        is_val_d  = is_val_q;
        is_data_d = is_data_q;
        widx_d    = widx_q;
        wwrap_d   = wwrap_q;
        ridx_d    = ridx_q;
        rwrap_d   = rwrap_q;
        if (op == OP_WR) begin
            is_val_d = 1'b0;
            widx_d   = winc[IDX_W-1:0];
            wwrap_d  = wwrap_q ^ winc[32];
        end
        if (op == OP_RD) begin
            ridx_d  = rinc[IDX_W-1:0];
            rwrap_d = rwrap_q ^ rinc[32];
        end
        if (push && !bypass) begin
            is_val_d  = 1'b1;
            is_data_d = in_data;
        end
    end

    // State register for the input stage and pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_val_q  <= 1'b0;
            is_data_q <= '0;
            widx_q    <= '0;
            wwrap_q   <= 1'b0;
            ridx_q    <= '0;
            rwrap_q   <= 1'b0;
        end else begin
            is_val_q  <= is_val_d;
            is_data_q <= is_data_d;
            widx_q    <= widx_d;
            wwrap_q   <= wwrap_d;
            ridx_q    <= ridx_d;
            rwrap_q   <= rwrap_d;
        end
    end

    sram_wrapper #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (IDX_W)
    ) u_sram (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (op != OP_IDLE),
        .we          (op == OP_WR),
        .addr        ((op == OP_WR) ? widx_q : ridx_q),
        .wdata       (is_data_q),
        .rdata       (sram_rdata),
        .rd_data_val (rd_data_val)
    );

    // The SRAM return and the bypass can never coincide (bypass needs no read in flight).
    assign ob_cap      = rd_data_val | bypass;
    assign ob_cap_data = rd_data_val ? sram_rdata : in_data;

    sram_fifo_v2_obuf #(
        .DATA_W (DATA_W)
    ) u_obuf (
        .clk        (clk),
        .rst_n      (rst_n),
        .cap_i      (ob_cap),
        .cap_data_i (ob_cap_data),
        .pop_i      (pop),
        .data_o     (out_data),
        .valid_o    (out_valid),
        .cnt_o      (ob_cnt)
    );

    // An in-flight read counts as held so occupancy never dips during prefetch.
    assign count = {{(CNT_W-1){1'b0}}, is_val_q} + sram_cnt
                 + {{(CNT_W-1){1'b0}}, rd_data_val} + {{(CNT_W-2){1'b0}}, ob_cnt};

    assign in_ready     = ~is_val_q;
    assign full         = is_val_q;
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_CNT);
    assign almost_empty = (count <= AE_CNT);

endmodule
`default_nettype wire

// File: tb/tb_sram_fifo_v2.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_fifo_v2
// Description : Self-checking bench for sram_fifo_v2 (DEPTH=8). A queue holds
//               the words the FIFO must contain; occupancy, flags and pop
//               data are compared against it every cycle.
// Revision    : 2.0 - initial release
// ============================================================================
module tb_sram_fifo_v2;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int CAP    = DEPTH + 3;
    localparam int AF     = 9;
    localparam int AE     = 2;
    localparam int CNT_W  = $clog2(DEPTH + 4);
`ifdef SRAM_FIFO_V2_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 4;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              mem_en = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_ready = 1'b0;
    logic              in_ready, out_valid, full, empty, almost_full, almost_empty;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  count;

    logic [DATA_W-1:0] model_q [$];
    int tests  = 0;
    int failed = 0;

    sram_fifo_v2 #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF),
        .AE_THRESH (AE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_en       (mem_en),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: compare against the model at negedge, then apply the handshakes at posedge.
    task automatic cycle();
        bit                do_push, do_pop;
        logic [DATA_W-1:0] pd;
        int                sz;
        @(negedge clk);
        sz = model_q.size();
        check("count", count, sz);
        check("empty", empty, sz == 0);
        check("almost_full", almost_full, sz >= AF);
        check("almost_empty", almost_empty, sz <= AE);
        check("full_vs_ready", full, !in_ready);
        if (sz == 0)   check("out_valid_when_empty", out_valid, 1'b0);
        if (sz == CAP) check("in_ready_at_capacity", in_ready, 1'b0);
        do_push = in_valid && in_ready;
        do_pop  = out_valid && out_ready && (sz > 0);
        if (do_pop) check("pop_data", out_data, model_q[0]);
        pd = in_data;
        @(posedge clk);
        if (do_pop)  void'(model_q.pop_front());
        if (do_push) model_q.push_back(pd);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic push_word(input logic [DATA_W-1:0] d);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 40 && !ok; i++) begin
            ok = in_ready;
            cycle();
        end
        in_valid = 1'b0;
        check("push_accepted", ok, 1'b1);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 200 && model_q.size() > 0; i++) cycle();
        out_ready = 1'b0;
        check("drain_done", model_q.size(), 0);
        idle(2);
    endtask

    initial begin
        int n;
        // Reset values while rst_n is held low.
        #12;
        check("rst_count", count, 0);
        check("rst_empty", empty, 1'b1);
        check("rst_almost_empty", almost_empty, 1'b1);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_full", full, 1'b0);
        check("rst_almost_full", almost_full, 1'b0);
        check("rst_out_data", out_data, 0);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        mem_en = 1'b1;

        // Five pushes without pops, then an asynchronous reset mid-operation.
        for (int i = 1; i <= 5; i++) push_word(32'hA5A5_0000 + i);
        idle(10);
        check("five_count", count, 5);
        check("five_out_valid", out_valid, 1'b1);
        check("five_head", out_data, 32'hA5A5_0001);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_count", count, 0);
        check("async_rst_empty", empty, 1'b1);
        check("async_rst_out_valid", out_valid, 1'b0);
        check("async_rst_in_ready", in_ready, 1'b1);
        model_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);

        // Fill to capacity; an extra push must be ignored; drain in order.
        for (int i = 0; i < CAP; i++) push_word(32'h1000_0000 + i);
        idle(6);
        check("fill_count", count, CAP);
        check("fill_in_ready", in_ready, 1'b0);
        check("fill_full", full, 1'b1);
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        idle(4);
        in_valid = 1'b0;
        check("overfill_count", count, CAP);
        drain();

        // Latency of a single push into an empty FIFO.
        in_valid = 1'b1;
        in_data  = 32'h0000_CAFE;
        cycle();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            cycle();
            n++;
        end
        check("latency", n, LAT);
        check("latency_data", out_data, 32'h0000_CAFE);
        drain();

        // mem_en low: only the output buffer drains; reads resume two cycles after.
        for (int i = 0; i < 6; i++) push_word(32'h2000_0000 + i);
        idle(8);
        check("memen_pre_count", count, 6);
        mem_en    = 1'b0;
        out_ready = 1'b1;
        idle(10);
        check("memen_ob_drained", out_valid, 1'b0);
        check("memen_held_count", count, 4);
        mem_en = 1'b1;
        n = 0;
        while (!out_valid && n < 20) begin
            cycle();
            n++;
        end
        check("memen_resume", n, 2);
        drain();

        // Random traffic with occasional mem_en stalls.
        for (int i = 0; i < 600; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            mem_en    = ($urandom_range(0, 7) != 0);
            cycle();
        end
        // Push-heavy phase to reach full and wrap the pointers repeatedly.
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) == 0);
            mem_en    = 1'b1;
            cycle();
        end
        in_valid = 1'b0;
        mem_en   = 1'b1;
        drain();
        check("final_empty", empty, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_fifo_v2.md
Name: sram_fifo_v2

Overview:
- Next-generation SRAM-backed FIFO for the EC accelerator datapath. Parametrised width and depth.
- Valid/ready handshakes on both sides; push and pop may occur in the same cycle.
- Arbitrates one single-port sram_wrapper between writes and prefetch reads.
- Exposes occupancy count and programmable almost-full/almost-empty flags for stream schedulers.

Parameters:
DATA_W, 32, data width in bits
DEPTH, 100, SRAM rows; any value ≥ 2 (power of two not required)
AF_THRESH, DEPTH, almost_full asserts when count ≥ AF_THRESH
AE_THRESH, 1, almost_empty asserts when count ≤ AE_THRESH
CNT_W, $clog2(DEPTH+4), count width (local, do not override)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
mem_en  in  1  SRAM enable; low blocks issue of new SRAM ops
in_valid  in  1  push request
in_ready  out  1  push accepted when in_valid & in_ready
in_data  in  DATA_W  push data
out_valid  out  1  head entry valid
out_ready  in  1  pop when out_valid & out_ready
out_data  out  DATA_W  head data
count  out  CNT_W  total entries held
full  out  1  = ~in_ready
empty  out  1  count == 0
almost_full  out  1  see AF_THRESH
almost_empty  out  1  see AE_THRESH

Behaviour:
- Clocking/reset: one clock domain; clk, with rst_n asynchronous active-low. Reset clears all valids, pointers and count; all outputs 0 except empty=1, almost_empty=1, in_ready=1. Reset mid-operation discards all contents, including any in-flight SRAM read.
- Storage path: input stage IS (1 entry) → SRAM (DEPTH) → output buffer OB (2 entries). Capacity = DEPTH+3.
- in_ready = ~is_val. Registered; no combinational path from out_ready.
- Accepted data goes to IS, or directly to OB when the bypass feature is compiled in.
- SRAM arbiter, one op per cycle, ops enum {OP_IDLE, OP_WR, OP_RD}:
  - OP_RD when mem_en & sram_cnt>0 & (ob_cnt + rd_inflight) < 2, where ob_cnt is the value after this cycle's pop.
  - Else OP_WR when mem_en & is_val & sram_cnt<DEPTH.
  - Else OP_IDLE.
  - Read has priority.
- SRAM read latency 1: data is captured into OB in the cycle rd_data_val is high.
- OB: FIFO order; out_data = head, out_valid = ob_cnt>0. A simultaneous capture and pop is allowed.
- Pointers: wptr/rptr carry a wrap bit. Index wraps from DEPTH-1 to 0 and toggles the wrap bit. sram_cnt is derived from the pointers.
- count = is_val + sram_cnt + rd_inflight + ob_cnt. Updated every edge; push+pop in the same cycle leaves it unchanged.
- Latency with empty FIFO, no bypass: push in cycle 0 → IS; cycle 1 OP_WR; cycle 2 OP_RD; cycle 3 capture; out_valid high in cycle 4.
- Throughput: aggregate SRAM traffic ≤ 1 op/cycle. Sustained push+pop rate ≤ 1 combined, by design.
- mem_en low: no new ops issued; an in-flight read still completes; handshakes continue against IS/OB.
- Pop on empty, or push when ~in_ready: ignored, no state change.

Optional Feature:
- Macro SRAM_FIFO_V2_BYPASS_EN.
- Defined: when is_val=0, sram_cnt=0, rd_inflight=0 and OB has room after this cycle's pop, an accepted push writes straight into OB. Push in cycle 0 → out_valid in cycle 1. Ordering is always preserved.
- Undefined: every entry traverses IS and SRAM; 4-cycle minimum latency.

Decomposition:
- Package sram_fifo_v2_pkg holds the op enum typedef (OP_IDLE/OP_WR/OP_RD) and a pointer-increment-with-wrap function taking DEPTH.
- Reuse the existing sram_wrapper for storage.
- One natural sub-module: sram_fifo_v2_obuf, the 2-entry output buffer with capture/pop and ob_cnt.

Test Plan:
- Reset, then push 0xA5A5_0001..0xA5A5_0005 with out_ready=0 → count=5 after the last push, out_valid=1, out_data=0xA5A5_0001; reassert rst_n low → count=0, empty=1 immediately.
- Fill with DEPTH=8: push 11 words, no pops → in_ready=0 at count=11; 12th push ignored; drain returns the 11 words in order.
- Wrap: DEPTH=5, 20 push/pop cycles at 50% rate → data in order; wptr/rptr wrap bits toggle every 5 SRAM ops.
- Simultaneous push+pop with count=3 steady → count remains 3; no data lost or duplicated over 100 cycles of random traffic checked by scoreboard.
- mem_en=0 for 10 cycles with 4 entries in SRAM → no SRAM ops; OB drains; out_valid resumes 2 cycles after mem_en=1.
- Latency: empty FIFO, single push → out_valid in cycle 4 without SRAM_FIFO_V2_BYPASS_EN, cycle 1 with it.
